regfile_en_bank: RTL and testbench

Parametrised multi-register storage bank built from enabled flip-flop bits. It provides a WIDTH×DEPTH register file with one write port and two combinational read ports. Extensions over a single enabled bit:
- byte-granular write enables
- optional hardwired zero register
- same-cycle write-to-read bypass
- synchronous bank clear
- per-register dirty tracking

It is the architectural register file for the datapath, read in decode and written in write-back.

---
 rtl/regfile_en_bank.sv | 107 ++++++++++
 tb/tb_regfile_en_bank.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_en_bank.sv
// Architectural register file: WIDTH x DEPTH enabled-flop storage with one
// byte-masked write port, two combinational read ports, bypass, clear and dirty bits.
module regfile_en_bank #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [WIDTH/8-1:0]       wr_be,
  input  logic                     clr,
  input  logic [$clog2(DEPTH)-1:0] rd_addr0,
  output logic [WIDTH-1:0]         rd_data0,
  input  logic [$clog2(DEPTH)-1:0] rd_addr1,
  output logic [WIDTH-1:0]         rd_data1,
  output logic [DEPTH-1:0]         dirty
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] be_mask;
  logic [WIDTH-1:0] wr_merged;
  logic             wr_zero_hit;
  logic             wr_accept;
  logic [WIDTH-1:0] rows [DEPTH];
  logic [DEPTH-1:0] dirty_q, dirty_d;

  always_comb begin
    be_mask = '0;
    for (int b = 0; b < NB; b++) begin
      be_mask[8*b +: 8] = {8{wr_be[b]}};
    end
  end

  // A write only counts if it can change state: not during reset or clear,
  // not aimed at the hardwired zero register, and with at least one byte enabled.
  assign wr_zero_hit = (ZERO_REG != 0) && (wr_addr == '0);
  assign wr_accept   = reset && wr_en && !clr && !wr_zero_hit && (wr_be != '0);

  // Byte-wise merge of the incoming data over the addressed register; this
  // is both the next value of that register and the bypass value.
  assign wr_merged = (rows[wr_addr] & ~be_mask) | (wr_data & be_mask);

  for (genvar r = 0; r < DEPTH; r++) begin : g_row
    if ((ZERO_REG != 0) && (r == 0)) begin : g_zero
      assign rows[r] = '0;
    end else begin : g_store
      logic [WIDTH-1:0] row_q;
      logic [WIDTH-1:0] row_d;
      logic             row_we;

      assign row_we = wr_accept && (wr_addr == AW'(r));
      assign row_d  = wr_merged;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          row_q <= '0;
        end else if (clr) begin
          row_q <= '0;
        end else if (row_we) begin
          row_q <= row_d;
        end
      end

      assign rows[r] = row_q;
    end
  end

  always_comb begin
    dirty_d = dirty_q;
    if (wr_accept) begin
      dirty_d[wr_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dirty_q <= '0;
    end else if (clr) begin
      dirty_q <= '0;
    end else begin
      dirty_q <= dirty_d;
    end
  end

  assign dirty = dirty_q;

  always_comb begin
    rd_data0 = rows[rd_addr0];
    if ((BYPASS != 0) && wr_accept && (rd_addr0 == wr_addr)) begin
      rd_data0 = wr_merged;
    end
  end

  always_comb begin
    rd_data1 = rows[rd_addr1];
    if ((BYPASS != 0) && wr_accept && (rd_addr1 == wr_addr)) begin
      rd_data1 = wr_merged;
    end
  end

endmodule

// File: tb/tb_regfile_en_bank.sv
// Bench for regfile_en_bank: one bypassing and one non-bypassing instance share
// stimulus; an array model is checked every cycle plus hand-computed literals.
module tb_regfile_en_bank;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_be;
  logic        clr;
  logic [4:0]  rd_addr0;
  logic [4:0]  rd_addr1;
  logic [63:0] b_rd0, b_rd1, n_rd0, n_rd1;
  logic [31:0] b_dirty, n_dirty;

  int n_cmp = 0;
  int n_err = 0;
  bit check_en = 0;

  logic [63:0] m_reg [32];
  logic [31:0] m_dirty;

  regfile_en_bank #(.WIDTH(64), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .clr(clr), .rd_addr0(rd_addr0), .rd_data0(b_rd0),
    .rd_addr1(rd_addr1), .rd_data1(b_rd1), .dirty(b_dirty)
  );

  regfile_en_bank #(.WIDTH(64), .DEPTH(32), .ZERO_REG(1), .BYPASS(0)) u_nb (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .clr(clr), .rd_addr0(rd_addr0), .rd_data0(n_rd0),
    .rd_addr1(rd_addr1), .rd_data1(n_rd1), .dirty(n_dirty)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < 32; r++) m_reg[r] <= 64'h0;
      m_dirty <= 32'h0;
    end else if (clr) begin
      for (int r = 0; r < 32; r++) m_reg[r] <= 64'h0;
      m_dirty <= 32'h0;
    end else if (wr_en && wr_addr != 5'd0 && wr_be != 8'h0) begin
      for (int b = 0; b < 8; b++)
        if (wr_be[b]) m_reg[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      m_dirty[wr_addr] <= 1'b1;
    end
  end

  function automatic logic [63:0] model_read(input logic [4:0] a, input bit byp);
    logic [63:0] v;
    if (!reset || a == 5'd0) return 64'h0;
    v = m_reg[a];
    if (byp && wr_en && !clr && a == wr_addr)
      for (int b = 0; b < 8; b++)
        if (wr_be[b]) v[8*b +: 8] = wr_data[8*b +: 8];
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("byp_rd0",   b_rd0, model_read(rd_addr0, 1'b1));
      check("byp_rd1",   b_rd1, model_read(rd_addr1, 1'b1));
      check("nb_rd0",    n_rd0, model_read(rd_addr0, 1'b0));
      check("nb_rd1",    n_rd1, model_read(rd_addr1, 1'b0));
      check("byp_dirty", {32'h0, b_dirty}, {32'h0, m_dirty});
      check("nb_dirty",  {32'h0, n_dirty}, {32'h0, m_dirty});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input logic [4:0] a, input logic [63:0] d, input logic [7:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_be = 8'h0; wr_data = 64'h0; clr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [63:0] seq_data [4];
  logic [7:0]  seq_be   [4];

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 64'h0; wr_be = 8'h0;
    clr = 1'b0; rd_addr0 = 5'd0; rd_addr1 = 5'd0;
    #12 reset = 1'b1;
    tick();
    check_en = 1;

    // seed reg4 so the mid-cycle reset has something to wipe
    drive_wr(5'd4, 64'h0F0F0F0F0F0F0F0F, 8'hFF);
    tick();
    idle(); rd_addr0 = 5'd4; rd_addr1 = 5'd4;
    #1 check("seed_reg4", b_rd0, 64'h0F0F0F0F0F0F0F0F);

    // reset asserted mid-cycle during a write
    drive_wr(5'd4, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
    #1 reset = 1'b0;
    #1;
    check("rst_rd0", b_rd0, 64'h0);
    check("rst_rd1", b_rd1, 64'h0);
    check("rst_nb_rd0", n_rd0, 64'h0);
    check("rst_dirty", {32'h0, b_dirty}, 64'h0);
    tick();
    idle();
    reset = 1'b1;
    #1 check("post_rst_reg4", b_rd0, 64'h0);

    // first write after release is accepted at the next edge
    drive_wr(5'd5, 64'h1122334455667788, 8'hFF);
    tick();
    drive_wr(5'd5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    tick();
    idle(); rd_addr0 = 5'd5;
    #1;
    check("merge_reg5", b_rd0, 64'h11223344AAAAAAAA);
    check("dirty5", {63'h0, b_dirty[5]}, 64'h1);

    // zero byte-enable write changes nothing
    drive_wr(5'd6, 64'h1234, 8'h00);
    tick();
    idle();
    #1 check("be0_dirty6", {63'h0, b_dirty[6]}, 64'h0);

    // same-cycle bypass versus non-bypass
    drive_wr(5'd7, 64'hDEADBEEF00000000, 8'hF0);
    rd_addr1 = 5'd7; rd_addr0 = 5'd6;
    #1;
    check("byp_same_cycle", b_rd1, 64'hDEADBEEF00000000);
    check("byp_other_port", b_rd0, 64'h0);
    check("nb_same_cycle", n_rd1, 64'h0);
    tick();
    idle();
    #1 check("nb_next_cycle", n_rd1, 64'hDEADBEEF00000000);

    // hardwired zero register
    drive_wr(5'd0, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
    rd_addr0 = 5'd0;
    #1 check("zero_same", b_rd0, 64'h0);
    tick();
    idle();
    #1;
    check("zero_next", b_rd0, 64'h0);
    check("zero_dirty", {63'h0, b_dirty[0]}, 64'h0);

    // dual-port read of one register
    drive_wr(5'd9, 64'h0123456789ABCDEF, 8'hFF);
    tick();
    idle(); rd_addr0 = 5'd9; rd_addr1 = 5'd9;
    #1;
    check("dual_rd0", b_rd0, 64'h0123456789ABCDEF);
    check("dual_rd1", b_rd1, 64'h0123456789ABCDEF);

    // clear wins over a simultaneous write
    drive_wr(5'd3, 64'h33, 8'hFF);
    tick();
    drive_wr(5'd3, 64'h5, 8'hFF);
    clr = 1'b1; rd_addr0 = 5'd3;
    #1 check("clr_old_value", b_rd0, 64'h33);
    tick();
    idle();
    #1;
    check("clr_reg3", b_rd0, 64'h0);
    check("clr_reg9", b_rd1, 64'h0);
    check("clr_dirty", {32'h0, b_dirty}, 64'h0);

    // back-to-back masked writes to one address
    seq_data[0] = 64'h0101010101010101; seq_be[0] = 8'hFF;
    seq_data[1] = 64'h2222222222222222; seq_be[1] = 8'h81;
    seq_data[2] = 64'h3333333333333333; seq_be[2] = 8'h3C;
    seq_data[3] = 64'h4444444444444444; seq_be[3] = 8'h01;
    rd_addr0 = 5'd12; rd_addr1 = 5'd13;
    for (int i = 0; i < 4; i++) begin
      drive_wr(5'd12, seq_data[i], seq_be[i]);
      tick();
    end
    idle();
    #1 check("b2b_merge", b_rd0, 64'h2201333333330144);

    // walk every register to exercise address decode and dirty bits
    for (int r = 1; r < 32; r++) begin
      drive_wr(r[4:0], {32'hC0DE0000 | r, 32'h00000100 * r}, 8'hFF);
      rd_addr0 = r[4:0]; rd_addr1 = 5'(r - 1);
      tick();
    end
    idle();
    #1 check("walk_dirty", {32'h0, b_dirty}, 64'hFFFFFFFE);

    tick();
    check_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
